rgb_binarizer: RTL and testbench
================================

RGB_BINARIZER -- requirements
Module: rgb_binarizer

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line; it must be a multiple of 8.
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  input pixel valid.
REQ-006 SHALL have port s_ready  output  1  block accepts a pixel this cycle.
REQ-007 SHALL have port s_sof  input  1  qualifies the accepted pixel as frame pixel (0,0).
REQ-008 SHALL have ports red_in, green_in, blue_in  input  8 each  input pixel colour.
REQ-009 SHALL have port threshold  input  8  luma compare level, sampled per accepted pixel.
REQ-010 SHALL have port invert  input  1  inverts the output bit, sampled per accepted pixel.
REQ-011 SHALL have port m_valid  output  1  packed byte valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts the byte.
REQ-013 SHALL have port m_data  output  8  eight 1-bit pixels; the first pixel is in bit 7.
REQ-014 SHALL have port m_eol  output  1  m_data is the last byte of a line.
REQ-015 SHALL have port m_eof  output  1  m_data is the last byte of a frame.
REQ-016 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-017 Acceptance SHALL be s_valid && s_ready.
REQ-018 s_ready SHALL equal !(m_valid && !m_ready).
REQ-019 Luma SHALL be (77*R + 150*G + 29*B) >> 8, computed at 16 bits with no overflow, giving a result in the range 0..255.
REQ-020 The pixel bit SHALL be (luma >= threshold) XOR invert.
REQ-021 FSM states SHALL be IDLE and ACTIVE; reset enters IDLE.
REQ-022 In IDLE, accepted pixels with s_sof=0 SHALL be discarded with no output.
REQ-023 In IDLE, an accepted pixel with s_sof=1 SHALL enter ACTIVE and count as pixel (0,0).
REQ-024 In ACTIVE, each accepted pixel SHALL shift into the pack register MSB-first and advance the bit count (0..7), byte column (0..IMG_W/8-1) and row (0..IMG_H-1) counters.
REQ-025 On acceptance of the 8th bit, the packed byte SHALL load m_data, m_valid=1 and m_eol/m_eof the next cycle; latency is 1 cycle.
REQ-026 The output register SHALL hold m_data/m_eol/m_eof stable while m_valid && !m_ready.
REQ-027 If m_valid && m_ready and a byte completes in the same cycle, the new byte SHALL load with m_valid staying 1; no bubble and no loss.
REQ-028 If m_valid && m_ready and no byte completes, m_valid SHALL go to 0.
REQ-029 Column wrap SHALL assert m_eol on the byte, zero the column and increment the row.
REQ-030 The last byte of the last row SHALL assert m_eol=1 and m_eof=1, zero all counters and return the FSM to IDLE.
REQ-031 An accepted s_sof=1 in ACTIVE other than at (0,0) SHALL pulse frame_err the next cycle, discard the partial pack register, and restart counters with this pixel as (0,0).
REQ-032 An already-loaded output byte SHALL still be delivered on a frame_err restart.

Reset
REQ-033 On rst_n=0, the block SHALL immediately (asynchronously) set m_valid=0, m_data=0, m_eol=0, m_eof=0, frame_err=0, counters=0 and FSM=IDLE.
REQ-034 While rst_n=0, s_ready SHALL be 1 because m_valid=0.
REQ-035 Reset during ACTIVE SHALL drop the partial byte and the pending output byte.
REQ-036 Reset deassertion SHALL take effect on the next clk edge.

Verification
REQ-037 With IMG_W=16 and IMG_H=2: pixels R=G=B=255, threshold=128, invert=0, 32 pixels with s_sof on the first -> four bytes 0xFF; m_eol on bytes 2 and 4; m_eof on byte 4 only.
REQ-038 Alternating pixels (255,255,255) and (0,0,0), threshold=128, invert=1 -> m_data=0x55 each byte.
REQ-039 Luma boundary: R=G=B=100 gives luma 100; threshold=100 gives bit 1; threshold=101 gives bit 0.
REQ-040 Hold m_ready=0 after the first byte -> s_ready=0 after that byte is loaded; m_data holds; no pixel is lost when m_ready returns to 1.
REQ-041 s_sof at pixel 5 of frame -> frame_err pulses for 1 cycle; the next byte contains pixels from the restart only; the frame completes 32 pixels later.
REQ-042 Assert rst_n=0 mid-byte -> outputs are 0 immediately; pixels without s_sof after release produce no output.

Source files
------------

// File: rtl/rgb_binarizer.sv
// RGB to 1-bit binarizer: luma threshold per pixel, packed 8 pixels per byte MSB-first.
// Tracks line/frame position to flag end-of-line/frame and malformed frames.
module rgb_binarizer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_sof,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic [7:0] threshold,
  input  logic       invert,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_eol,
  output logic       m_eof,
  output logic       frame_err
);

  localparam int COLS = IMG_W / 8;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [6:0]    pack_q, pack_d;
  logic          err_q, err_d;
  logic [7:0]    data_q;
  logic          valid_q, eol_q, eof_q;

  logic [15:0] luma_sum;
  logic [7:0]  luma;
  logic        px;
  logic        acc;
  logic        at_origin;
  logic        start, restart, finish, shift;
  logic        done;
  logic        eol_d, eof_d;
  logic [7:0]  byte_d;

  // Weights sum to 256, so the 16-bit sum cannot overflow.
  assign luma_sum = 16'd77 * 16'(red_in)
                  + 16'd150 * 16'(green_in)
                  + 16'd29 * 16'(blue_in);
  assign luma = 8'(luma_sum >> 8);
  assign px   = (luma >= threshold) ^ invert;

  assign s_ready = !(valid_q && !m_ready);
  assign acc     = s_valid && s_ready;

  assign at_origin = (cnt_q == 3'd0) && (col_q == '0)
                  && (row_q == '0);

  assign start   = acc && (state_q == IDLE) && s_sof;
  assign restart = acc && (state_q == ACTIVE)
                && s_sof && !at_origin;
  assign finish  = acc && (state_q == ACTIVE)
                && !restart && (cnt_q == 3'd7);
  assign shift   = acc && (state_q == ACTIVE)
                && !restart && (cnt_q != 3'd7);

  assign byte_d = {pack_q, px};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    pack_d  = pack_q;
    err_d   = 1'b0;
    done    = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    unique case (1'b1)
      start, restart: begin
        err_d   = restart;
        state_d = ACTIVE;
        pack_d  = {6'd0, px};
        cnt_d   = 3'd1;
        col_d   = '0;
        row_d   = '0;
      end
      finish: begin
        done   = 1'b1;
        cnt_d  = 3'd0;
        pack_d = '0;
        eol_d  = (col_q == COL_LAST);
        eof_d  = eol_d && (row_q == ROW_LAST);
        if (eof_d) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else if (eol_d) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      shift: begin
        pack_d = {pack_q[5:0], px};
        cnt_d  = cnt_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pack_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pack_q  <= pack_d;
      err_q   <= err_d;
    end
  end

  // A byte can only complete when the output slot is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (done) begin
      data_q  <= byte_d;
      valid_q <= 1'b1;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end else if (valid_q && m_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign m_eol     = eol_q;
  assign m_eof     = eof_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_rgb_binarizer.sv
// Directed bench for rgb_binarizer on a 16x2 frame.
// Output bytes are collected by a monitor and compared to hand-computed frames.
module tb_rgb_binarizer;

  localparam int W = 16;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       s_sof = 1'b0;
  logic [7:0] red_in = '0;
  logic [7:0] green_in = '0;
  logic [7:0] blue_in = '0;
  logic [7:0] threshold = '0;
  logic       invert = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_eol;
  logic       m_eof;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  logic [9:0] q[$];

  rgb_binarizer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_sof(s_sof),
    .red_in(red_in),
    .green_in(green_in),
    .blue_in(blue_in),
    .threshold(threshold),
    .invert(invert),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_eol(m_eol),
    .m_eof(m_eof),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (rst_n && m_valid && m_ready)
      q.push_back({m_data, m_eol, m_eof});
    if (frame_err)
      err_pulses++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_px(input logic [7:0] r,
                         input logic [7:0] g,
                         input logic [7:0] b,
                         input logic [7:0] thr,
                         input logic inv,
                         input logic sof);
    int n;
    n = 0;
    red_in = r;
    green_in = g;
    blue_in = b;
    threshold = thr;
    invert = inv;
    s_sof = sof;
    s_valid = 1'b1;
    #1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $error("FAIL accept_timeout observed=%0d expected=<50", n);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic inv,
                           input logic sof);
    for (int i = 7; i >= 0; i--) begin
      if (b[i] ^ inv)
        send_px(8'd255, 8'd255, 8'd255, 8'd128, inv, sof && i == 7);
      else
        send_px(8'd0, 8'd0, 8'd0, 8'd128, inv, sof && i == 7);
    end
  endtask

  task automatic exp_frame(input logic [7:0] b0,
                           input logic [7:0] b1,
                           input logic [7:0] b2,
                           input logic [7:0] b3);
    logic [7:0] e[4];
    e[0] = b0;
    e[1] = b1;
    e[2] = b2;
    e[3] = b3;
    repeat (3) @(negedge clk);
    chk("frame_bytes", q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) begin
        chk("byte_data", {24'd0, q[i][9:2]}, {24'd0, e[i]});
        chk("byte_eol", {31'd0, q[i][1]}, {31'd0, i[0]});
        chk("byte_eof", {31'd0, q[i][0]}, (i == 3) ? 1 : 0);
      end
    end
    q.delete();
  endtask

  initial begin
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_eol", m_eol, 0);
    chk("rst_m_eof", m_eof, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_s_ready", s_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    repeat (3) send_px(8'd255, 8'd255, 8'd255, 8'd128, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_discard", q.size(), 0);

    for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0, i == 0);
    exp_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);

    for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b1, i == 0);
    exp_frame(8'h55, 8'h55, 8'h55, 8'h55);

    for (int i = 0; i < 8; i++)
      send_px(8'd100, 8'd100, 8'd100,
              (i % 2 == 1) ? 8'd101 : 8'd100, 1'b0, i == 0);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b0, 1'b0);
    exp_frame(8'hAA, 8'hFF, 8'hFF, 8'hFF);

    m_ready = 1'b0;
    send_byte(8'hF0, 1'b0, 1'b1);
    #1;
    chk("bp_m_valid", m_valid, 1);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_data", m_data, 8'hF0);
    red_in = 8'd0;
    green_in = 8'd0;
    blue_in = 8'd0;
    threshold = 8'd128;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("bp_hold_ready", s_ready, 0);
    chk("bp_hold_data", m_data, 8'hF0);
    chk("bp_hold_eol", m_eol, 0);
    m_ready = 1'b1;
    send_byte(8'h0F, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    exp_frame(8'hF0, 8'h0F, 8'h3C, 8'hC3);

    err_pulses = 0;
    send_px(8'd255, 8'd255, 8'd255, 8'd128, 1'b0, 1'b1);
    repeat (4) send_px(8'd255, 8'd255, 8'd255, 8'd128, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    exp_frame(8'hA5, 8'h5A, 8'h33, 8'hCC);
    chk("err_pulses", err_pulses, 1);

    m_ready = 1'b0;
    send_byte(8'h81, 1'b0, 1'b1);
    #1;
    chk("pre_rst_m_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_rst_no_out", q.size(), 0);
    q.delete();

    for (int i = 0; i < 4; i++)
      send_byte(8'h12 + 8'(i * 34), 1'b0, i == 0);
    exp_frame(8'h12, 8'h34, 8'h56, 8'h78);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
